video_mem_sched: RTL

- Slot scheduler for the shared DRAM port.
- Divides DRAM cycles, each delimited by a cend pulse, among three requesters: video fetch, CPU and DMA.
- Guarantees video its configured bandwidth, gives CPU priority in the remaining slots, and bounds DMA starvation.
- Sits between the video top level (video_go/video_bw/video_addr) and the DRAM controller; it produces the video_next/video_strobe handshake that the fetch and address generators consume.

---
 rtl/video_mem_sched_pkg.sv | 41 ++++
 rtl/video_mem_sched_if.sv | 55 +++++
 rtl/video_mem_slotmask.sv | 30 +++
 rtl/video_mem_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/video_mem_sched_pkg.sv
// Shared definitions for the DRAM slot scheduler.
//   owner_e  : owner encoding driven on the owner port and used internally
//   bw_e     : video bandwidth encoding (video_bw port)
//   SLOT_W   : width of the DRAM slot counter
//   STARVE_W : width of the DMA starvation counter
//   owner_onehot() : owner -> {dma, cpu, video} one-hot pulse vector
package video_mem_sched_pkg;

  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned STARVE_W   = 4;
  localparam int unsigned STARVE_MAX = 15;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'b00,
    OWN_VIDEO = 2'b01,
    OWN_CPU   = 2'b10,
    OWN_DMA   = 2'b11
  } owner_e;

  typedef enum logic [1:0] {
    BW_NONE = 2'b00,
    BW_8    = 2'b01,
    BW_4    = 2'b10,
    BW_2    = 2'b11
  } bw_e;

  // Bit 0 video, bit 1 CPU, bit 2 DMA; idle maps to no pulse.
  function automatic logic [2:0] owner_onehot(input owner_e own);
    logic [2:0] vec;
    vec = 3'b000;
    unique case (own)
      OWN_IDLE:  vec = 3'b000;
      OWN_VIDEO: vec = 3'b001;
      OWN_CPU:   vec = 3'b010;
      OWN_DMA:   vec = 3'b100;
      default:   vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/video_mem_sched_if.sv
// Bundle of requester handshakes and DRAM command signals around the scheduler.
//   slave  : scheduler side (samples requests and cend, drives grants/strobes/dram_*)
//   master : environment side (video top level, CPU, DMA, DRAM controller)
interface video_mem_sched_if #(
  parameter int unsigned ADDR_W = 21
) ();

  logic              cend;

  logic              video_go;
  logic [1:0]        video_bw;
  logic [ADDR_W-1:0] video_addr;
  logic              video_next;
  logic              video_strobe;

  logic              cpu_req;
  logic              cpu_rnw;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_next;
  logic              cpu_strobe;

  logic              dma_req;
  logic              dma_rnw;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_next;
  logic              dma_strobe;

  logic              dram_req;
  logic              dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0]        owner;

  modport slave (
    input  cend,
    input  video_go, video_bw, video_addr,
    output video_next, video_strobe,
    input  cpu_req, cpu_rnw, cpu_addr,
    output cpu_next, cpu_strobe,
    input  dma_req, dma_rnw, dma_addr,
    output dma_next, dma_strobe,
    output dram_req, dram_rnw, dram_addr, owner
  );

  modport master (
    output cend,
    output video_go, video_bw, video_addr,
    input  video_next, video_strobe,
    output cpu_req, cpu_rnw, cpu_addr,
    input  cpu_next, cpu_strobe,
    output dma_req, dma_rnw, dma_addr,
    input  dma_next, dma_strobe,
    input  dram_req, dram_rnw, dram_addr, owner
  );

endinterface

// File: rtl/video_mem_slotmask.sv
// Combinational video-slot decoder: flags whether a DRAM slot belongs to video.
//   slot       : slot index being allocated
//   video_bw   : bandwidth select (none, 1/8, 1/4, 1/2)
//   video_go   : fetch window active; slots are only claimed while high
//   video_slot : slot is reserved for video
module video_mem_slotmask
  import video_mem_sched_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic [1:0]        video_bw,
  input  logic              video_go,
  output logic              video_slot
);

  logic bw_hit;

  always_comb begin
    bw_hit = 1'b0;
    unique case (bw_e'(video_bw))
      BW_NONE: bw_hit = 1'b0;
      BW_8:    bw_hit = (slot == '0);
      BW_4:    bw_hit = (slot[1:0] == 2'b00);
      BW_2:    bw_hit = ~slot[0];
      default: bw_hit = 1'b0;
    endcase
  end

  assign video_slot = bw_hit & video_go;

endmodule

// File: rtl/video_mem_sched.sv
// DRAM slot scheduler. Each cend pulse closes one DRAM cycle and allocates the next
// among video fetch, CPU and DMA: video gets its reserved slots, CPU wins the free
// ones, and DMA wins a free slot once it has lost DMA_STARVE of them in a row.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : requester handshakes, cend, and registered dram_*/owner outputs
module video_mem_sched
  import video_mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned DMA_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  video_mem_sched_if.slave  bus
);

  logic [SLOT_W-1:0]   slot_q, slot_d, slot_inc;
  logic [STARVE_W-1:0] starve_q, starve_d;
  owner_e              owner_q, owner_d, grant;
  logic                dram_req_q, dram_req_d;
  logic                dram_rnw_q, dram_rnw_d;
  logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
  // {dma, cpu, video}
  logic [2:0]          next_q, next_d;
  logic [2:0]          strobe_q, strobe_d;
  logic                video_slot;
  logic                dma_starved;

  // The slot being allocated is the counter value after this cend's increment.
  assign slot_inc    = slot_q + 3'd1;
  assign dma_starved = (starve_q >= STARVE_W'(DMA_STARVE));

  video_mem_slotmask u_slotmask (
    .slot       (slot_inc),
    .video_bw   (bus.video_bw),
    .video_go   (bus.video_go),
    .video_slot (video_slot)
  );

  always_comb begin
    grant = OWN_IDLE;
    if (video_slot) begin
      grant = OWN_VIDEO;
    end else if (bus.dma_req && dma_starved) begin
      grant = OWN_DMA;
    end else if (bus.cpu_req) begin
      grant = OWN_CPU;
    end else if (bus.dma_req) begin
      grant = OWN_DMA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_IDLE;
      dram_req_q  <= 1'b0;
      dram_rnw_q  <= 1'b1;
      dram_addr_q <= '0;
      next_q      <= '0;
      strobe_q    <= '0;
    end else begin
      slot_q      <= slot_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      dram_req_q  <= dram_req_d;
      dram_rnw_q  <= dram_rnw_d;
      dram_addr_q <= dram_addr_d;
      next_q      <= next_d;
      strobe_q    <= strobe_d;
    end
  end

  always_comb begin
    slot_d      = slot_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    dram_req_d  = dram_req_q;
    dram_rnw_d  = dram_rnw_q;
    dram_addr_d = dram_addr_q;
    next_d      = '0;
    strobe_d    = '0;
    if (bus.cend) begin
      slot_d   = slot_inc;
      owner_d  = grant;
      next_d   = owner_onehot(grant);
      // The cycle owned until now completes at this cend.
      strobe_d = owner_onehot(owner_q);
      unique case (grant)
        OWN_VIDEO: begin
          dram_req_d  = 1'b1;
          dram_rnw_d  = 1'b1;
          dram_addr_d = bus.video_addr;
        end
        OWN_CPU: begin
          dram_req_d  = 1'b1;
          dram_rnw_d  = bus.cpu_rnw;
          dram_addr_d = bus.cpu_addr;
        end
        OWN_DMA: begin
          dram_req_d  = 1'b1;
          dram_rnw_d  = bus.dma_rnw;
          dram_addr_d = bus.dma_addr;
        end
        default: begin
          // Idle cycle: address is held, direction parks at read.
          dram_req_d = 1'b0;
          dram_rnw_d = 1'b1;
        end
      endcase
      if (!bus.dma_req || grant == OWN_DMA) begin
        starve_d = '0;
      end else if (grant == OWN_CPU && starve_q != STARVE_W'(STARVE_MAX)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    bus.owner        = owner_q;
    bus.dram_req     = dram_req_q;
    bus.dram_rnw     = dram_rnw_q;
    bus.dram_addr    = dram_addr_q;
    bus.video_next   = next_q[0];
    bus.cpu_next     = next_q[1];
    bus.dma_next     = next_q[2];
    bus.video_strobe = strobe_q[0];
    bus.cpu_strobe   = strobe_q[1];
    bus.dma_strobe   = strobe_q[2];
  end

endmodule
